// File: rtl/ahb_frame_mapper_if.sv
// Serial-in / AHB-field-out bundle for ahb_frame_mapper.
// slave = mapper side, master = SPI front end plus downstream consumer.
interface ahb_frame_mapper_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_from_slave;
    logic              bit_valid;
    logic              sof;
    logic              out_ready;
    logic              hwrite;
    logic              hreadyin;
    logic [1:0]        htrans;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] prdata;
    logic              out_valid;
    logic              frame_err;
    logic [1:0]        err_code;
    logic              busy;

    modport slave (
        input  data_from_slave, bit_valid, sof, out_ready,
        output hwrite, hreadyin, htrans, haddr, hwdata, prdata,
        output out_valid, frame_err, err_code, busy
    );

    modport master (
        output data_from_slave, bit_valid, sof, out_ready,
        input  hwrite, hreadyin, htrans, haddr, hwdata, prdata,
        input  out_valid, frame_err, err_code, busy
    );
endinterface

// File: rtl/ahb_frame_mapper.sv
// Serial-to-AHB field mapper: sof-aligned MSB-first frame, optional even
// parity, single-entry output buffer with valid/ready and error codes.
module ahb_frame_mapper #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    ahb_frame_mapper_if.slave bus
);
    localparam int FRAME_W   = 4 + ADDR_W + 2 * DATA_W;
    localparam int FRAME_LEN = FRAME_W + PARITY_EN;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int A_HI      = FRAME_LEN - 5;
    localparam int W_HI      = A_HI - ADDR_W;
    localparam int R_HI      = W_HI - DATA_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [FRAME_LEN-1:0]  r_shift;
    logic [FRAME_LEN-1:0]  w_shift_nxt;
    logic [FRAME_LEN-1:0]  w_first;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_par_bad;
    logic                  w_load;
    logic                  w_err;
    logic [1:0]            w_err_code;

    logic                  r_hwrite;
    logic                  r_hreadyin;
    logic [1:0]            r_htrans;
    logic [ADDR_W-1:0]     r_haddr;
    logic [DATA_W-1:0]     r_hwdata;
    logic [DATA_W-1:0]     r_prdata;
    logic                  r_out_valid;
    logic                  r_frame_err;
    logic [1:0]            r_err_code;
    logic                  r_busy;

    assign w_first   = {{(FRAME_LEN-1){1'b0}}, bus.data_from_slave};
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_par_bad = (PARITY_EN != 0) && (^r_shift);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A sof in CHECK starts the next frame while this one is being judged.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_err       = 1'b0;
        w_err_code  = r_err_code;
        unique case (r_state)
            S_IDLE: begin
                if (bus.bit_valid && bus.sof) begin
                    w_shift_nxt = w_first;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.bit_valid && bus.sof) begin
                    w_err       = 1'b1;
                    w_err_code  = 2'b10;
                    w_shift_nxt = w_first;
                    w_cnt_nxt   = CNT_W'(1);
                end else if (bus.bit_valid) begin
                    w_shift_nxt = {r_shift[FRAME_LEN-2:0],
                                   bus.data_from_slave};
                    w_cnt_nxt   = w_cnt_inc;
                    if (w_cnt_inc == LAST) begin
                        w_state_nxt = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                if (w_par_bad) begin
                    w_err      = 1'b1;
                    w_err_code = 2'b01;
                end else if (r_out_valid && !bus.out_ready) begin
                    w_err      = 1'b1;
                    w_err_code = 2'b11;
                end else begin
                    w_load = 1'b1;
                end
                if (bus.bit_valid && bus.sof) begin
                    w_shift_nxt = w_first;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = S_SHIFT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Fields only move on a load; a plain accept just drops out_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hwrite    <= 1'b0;
            r_hreadyin  <= 1'b0;
            r_htrans    <= 2'b00;
            r_haddr     <= '0;
            r_hwdata    <= '0;
            r_prdata    <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_hwrite    <= r_shift[FRAME_LEN-1];
            r_hreadyin  <= r_shift[FRAME_LEN-2];
            r_htrans    <= r_shift[FRAME_LEN-3 -: 2];
            r_haddr     <= r_shift[A_HI -: ADDR_W];
            r_hwdata    <= r_shift[W_HI -: DATA_W];
            r_prdata    <= r_shift[R_HI -: DATA_W];
            r_out_valid <= 1'b1;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_err <= 1'b0;
            r_err_code  <= 2'b00;
            r_busy      <= 1'b0;
        end else begin
            r_frame_err <= w_err;
            r_err_code  <= w_err_code;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.hwrite    = r_hwrite;
    assign bus.hreadyin  = r_hreadyin;
    assign bus.htrans    = r_htrans;
    assign bus.haddr     = r_haddr;
    assign bus.hwdata    = r_hwdata;
    assign bus.prdata    = r_prdata;
    assign bus.out_valid = r_out_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.err_code  = r_err_code;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_ahb_frame_mapper.sv
// Randomised scoreboard bench for ahb_frame_mapper: default build plus a
// narrow no-parity build (16/8/0) sharing clock and reset.
module tb_ahb_frame_mapper;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ahb_frame_mapper_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    ahb_frame_mapper_if #(.ADDR_W(16), .DATA_W(8))  b2 ();

    ahb_frame_mapper #(.ADDR_W(32), .DATA_W(32), .PARITY_EN(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(b1)
    );
    ahb_frame_mapper #(.ADDR_W(16), .DATA_W(8), .PARITY_EN(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(b2)
    );

    typedef struct packed {
        logic        hw;
        logic        hr;
        logic [1:0]  ht;
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] r;
    } fr_t;

    int total = 0;
    int bad = 0;
    fr_t ef1[$];
    fr_t ef2[$];
    logic [1:0] eq1[$];
    fr_t mf1, mf2;
    logic [1:0] me1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic fr_t rnd_fr();
        fr_t f;
        f.hw = 1'($urandom);
        f.hr = 1'($urandom);
        f.ht = 2'($urandom);
        f.a  = $urandom;
        f.w  = $urandom;
        f.r  = $urandom;
        return f;
    endfunction

    // Frame as sent: fields in order, then the bit that makes XOR even.
    function automatic logic [100:0] mk1(input fr_t f, input bit pbad);
        logic [99:0] b;
        b = {f.hw, f.hr, f.ht, f.a, f.w, f.r};
        return {b, (^b) ^ pbad};
    endfunction

    function automatic logic [35:0] mk2(input fr_t f);
        return {f.hw, f.hr, f.ht, f.a[15:0], f.w[7:0], f.r[7:0]};
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) sync();
    endtask

    task automatic drive1(input logic b, input logic s);
        b1.bit_valid = 1'b1;
        b1.data_from_slave = b;
        b1.sof = s;
        sync();
        b1.bit_valid = 1'b0;
        b1.sof = 1'b0;
    endtask

    task automatic drive2(input logic b, input logic s);
        b2.bit_valid = 1'b1;
        b2.data_from_slave = b;
        b2.sof = s;
        sync();
        b2.bit_valid = 1'b0;
        b2.sof = 1'b0;
    endtask

    function automatic int gap_n(input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return int'($urandom_range(0, 3));
        return 0;
    endfunction

    task automatic send1(input logic [100:0] fb, input int nb,
                         input int mode);
        for (int i = 0; i < nb; i++) begin
            drive1(fb[100-i], i == 0);
            if (i < nb - 1) idle(gap_n(mode));
        end
    endtask

    task automatic send2(input logic [35:0] fb, input int mode);
        for (int i = 0; i < 36; i++) begin
            drive2(fb[35-i], i == 0);
            if (i < 35) idle(gap_n(mode));
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (b1.frame_err) begin
                if (eq1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL err_unexpected: got code %b want none",
                             b1.err_code);
                end else begin
                    me1 = eq1.pop_front();
                    chk("err_code", 128'(b1.err_code), 128'(me1));
                end
            end
            if (b1.out_valid && b1.out_ready) begin
                if (ef1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL frame_unexpected: got addr %h want none",
                             b1.haddr);
                end else begin
                    mf1 = ef1.pop_front();
                    chk("fields",
                        128'({b1.hwrite, b1.hreadyin, b1.htrans, b1.haddr,
                              b1.hwdata, b1.prdata}),
                        128'({mf1.hw, mf1.hr, mf1.ht, mf1.a, mf1.w, mf1.r}));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (b2.frame_err) begin
                total++;
                bad++;
                $display("FAIL sweep_err: got code %b want none",
                         b2.err_code);
            end
            if (b2.out_valid && b2.out_ready) begin
                if (ef2.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sweep_unexpected: got addr %h want none",
                             b2.haddr);
                end else begin
                    mf2 = ef2.pop_front();
                    chk("sweep_fields",
                        128'({b2.hwrite, b2.hreadyin, b2.htrans, b2.haddr,
                              b2.hwdata, b2.prdata}),
                        128'(mk2(mf2)));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fr_t tp, fa, fb, fc;
        int k;
        bit pb;
        int gm;
        b1.bit_valid = 1'b0;
        b1.sof = 1'b0;
        b1.data_from_slave = 1'b0;
        b1.out_ready = 1'b0;
        b2.bit_valid = 1'b0;
        b2.sof = 1'b0;
        b2.data_from_slave = 1'b0;
        b2.out_ready = 1'b0;
        idle(3);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", 128'(b1.out_valid), 128'(0));
        chk("rst_busy", 128'(b1.busy), 128'(0));
        chk("rst_code", 128'(b1.err_code), 128'(0));
        sync();

        tp.hw = 1'b0;
        tp.hr = 1'b1;
        tp.ht = 2'b00;
        tp.a = 32'h8000000C;
        tp.w = 32'hFFFFFFFF;
        tp.r = 32'h56781234;

        eq1.push_back(2'b01);
        send1(mk1(tp, 1'b1), 101, 0);
        @(negedge clk);
        @(negedge clk);
        chk("par_valid", 128'(b1.out_valid), 128'(0));
        chk("par_fields", 128'({b1.hwrite, b1.hreadyin, b1.htrans,
                                b1.haddr, b1.hwdata, b1.prdata}), 128'(0));
        sync();

        ef1.push_back(tp);
        send1(mk1(tp, 1'b0), 101, 0);
        @(negedge clk);
        chk("latency_valid", 128'(b1.out_valid), 128'(0));
        @(negedge clk);
        chk("good_valid", 128'(b1.out_valid), 128'(1));
        chk("good_hwrite", 128'(b1.hwrite), 128'(0));
        chk("good_hreadyin", 128'(b1.hreadyin), 128'(1));
        chk("good_htrans", 128'(b1.htrans), 128'(0));
        chk("good_haddr", 128'(b1.haddr), 128'(32'h8000000C));
        chk("good_hwdata", 128'(b1.hwdata), 128'(32'hFFFFFFFF));
        chk("good_prdata", 128'(b1.prdata), 128'(32'h56781234));
        chk("good_noerr", 128'(b1.frame_err), 128'(0));
        sync();
        b1.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("accept_clear", 128'(b1.out_valid), 128'(0));
        sync();

        fa = rnd_fr();
        eq1.push_back(2'b10);
        ef1.push_back(fa);
        send1(mk1(rnd_fr(), 1'b0), 40, 0);
        send1(mk1(fa, 1'b0), 101, 0);
        idle(4);

        b1.out_ready = 1'b0;
        fa = rnd_fr();
        fb = rnd_fr();
        ef1.push_back(fa);
        eq1.push_back(2'b11);
        send1(mk1(fa, 1'b0), 101, 0);
        send1(mk1(fb, 1'b0), 101, 0);
        @(negedge clk);
        @(negedge clk);
        chk("ovr_hold_valid", 128'(b1.out_valid), 128'(1));
        chk("ovr_hold_addr", 128'(b1.haddr), 128'(fa.a));
        sync();
        b1.out_ready = 1'b1;
        idle(3);

        b1.out_ready = 1'b0;
        fa = rnd_fr();
        fc = rnd_fr();
        ef1.push_back(fa);
        ef1.push_back(fc);
        send1(mk1(fa, 1'b0), 101, 0);
        idle(5);
        send1(mk1(fc, 1'b0), 101, 0);
        b1.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("repl_valid", 128'(b1.out_valid), 128'(1));
        chk("repl_addr", 128'(b1.haddr), 128'(fc.a));
        sync();
        idle(3);

        fa = rnd_fr();
        ef1.push_back(fa);
        send1(mk1(fa, 1'b0), 101, 1);
        idle(4);

        send1(mk1(rnd_fr(), 1'b0), 60, 0);
        @(negedge clk);
        chk("mid_busy", 128'(b1.busy), 128'(1));
        sync();
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst2_fields", 128'({b1.hwrite, b1.hreadyin, b1.htrans,
                                 b1.haddr, b1.hwdata, b1.prdata}), 128'(0));
        chk("rst2_valid", 128'(b1.out_valid), 128'(0));
        chk("rst2_busy", 128'(b1.busy), 128'(0));
        chk("rst2_err", 128'({b1.frame_err, b1.err_code}), 128'(0));
        sync();
        reset_n = 1'b1;
        idle(2);
        fa = rnd_fr();
        ef1.push_back(fa);
        send1(mk1(fa, 1'b0), 101, 0);
        idle(3);

        for (int n = 0; n < 40; n++) begin
            fa = rnd_fr();
            pb = ($urandom_range(0, 4) == 0);
            gm = int'($urandom_range(0, 2));
            if ($urandom_range(0, 5) == 0) begin
                k = int'($urandom_range(1, 100));
                eq1.push_back(2'b10);
                send1(mk1(rnd_fr(), 1'b0), k, gm);
            end
            if (pb) eq1.push_back(2'b01);
            else ef1.push_back(fa);
            send1(mk1(fa, pb), 101, gm);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(10);
        chk("drain_frames", 128'(ef1.size()), 128'(0));
        chk("drain_errs", 128'(eq1.size()), 128'(0));

        b2.out_ready = 1'b1;
        for (int n = 0; n < 14; n++) begin
            fa = rnd_fr();
            ef2.push_back(fa);
            send2(mk2(fa), int'($urandom_range(0, 2)));
        end
        idle(10);
        chk("sweep_drain", 128'(ef2.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
